param_seq_divider: RTL and testbench
====================================

PARAM_SEQ_DIVIDER -- requirements
Module: param_seq_divider

Interface
REQ-001 Parameter DW, default 16: dividend/divisor width in bits; SHALL be >= 2.
REQ-002 Parameter QW, default 8: quotient width; SHALL satisfy 1 <= QW <= DW+FRAC.
REQ-003 Parameter FRAC, default 8: fractional bits appended to the dividend; SHALL be >= 0.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 nRst  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  request; sampled only in IDLE or DONE.
REQ-007 dividend  in  DW  unsigned numerator; captured on the accepting edge.
REQ-008 divisor  in  DW  unsigned denominator; captured on the accepting edge.
REQ-009 quotient  out  QW  registered result; holds until the next result.
REQ-010 remainder  out  DW  registered remainder; present only under DIVIDER_REMAINDER_EN.
REQ-011 busy  out  1  high in LOAD and DIVIDE.
REQ-012 valid  out  1  one-cycle pulse on the first DONE cycle.
REQ-013 div_by_zero  out  1  flag for the last result; holds with quotient.
REQ-014 overflow  out  1  flag for the last result; holds with quotient.

Function
REQ-015 Result SHALL be quotient = floor((dividend << FRAC) / divisor), unsigned, restoring algorithm, one quotient bit per cycle.
REQ-016 States SHALL be IDLE, LOAD, DIVIDE, DONE; the enum SHALL be 2 bits wide.
REQ-017 IDLE/DONE: start=1 -> capture operands, go to LOAD; start=0 -> stay.
REQ-018 LOAD: divisor==0 -> DONE, quotient all-ones, div_by_zero=1, overflow=0, remainder=0.
REQ-019 LOAD: (dividend << FRAC) >= (divisor << QW) -> DONE, quotient all-ones, overflow=1, div_by_zero=0, remainder=0.
REQ-020 Otherwise LOAD SHALL initialise the working remainder to dividend << FRAC and the counter to 0, then go to DIVIDE.
REQ-021 Working datapath SHALL be DW+FRAC+1 bits wide so that no compare or subtract truncates.
REQ-022 DIVIDE: each cycle, compare against divisor aligned to the current bit; subtract and shift in 1 if >=, else shift in 0; increment the counter.
REQ-023 DIVIDE SHALL exit to DONE after exactly QW iterations, loading quotient, remainder and flags (both flags 0).
REQ-024 Latency: on the normal path, valid SHALL be high QW+2 cycles after the accepting edge (10 at defaults); on the zero/overflow path, 2 cycles.
REQ-025 start during LOAD/DIVIDE SHALL be ignored without corrupting the operation in flight.
REQ-026 start=1 on the valid cycle SHALL begin a new operation; valid still pulses for exactly that one cycle.
REQ-027 quotient, remainder and the flags SHALL change only on entry to DONE.

Reset
REQ-028 nRst low SHALL asynchronously force IDLE, counter=0, working registers=0, quotient=0, remainder=0, busy=0, valid=0, div_by_zero=0, overflow=0.
REQ-029 Reset asserted mid-operation SHALL abort that operation; no valid SHALL follow release until a new start.

Configuration
REQ-030 Macro DIVIDER_REMAINDER_EN defined: the remainder port and its register SHALL exist, with remainder = (dividend << FRAC) mod divisor.
REQ-031 Macro DIVIDER_REMAINDER_EN undefined: the remainder port and its register SHALL be absent; all other behaviour and timing SHALL be identical.

Verification (defaults DW=16, QW=8, FRAC=8; remainder checks under DIVIDER_REMAINDER_EN)
REQ-032 dividend=1, divisor=4, start pulse -> busy for 9 cycles; valid 10 cycles after the accepting edge; quotient=0x40, remainder=0, both flags 0.
REQ-033 dividend=3, divisor=7 -> quotient=109 (0x6D), remainder=5.
REQ-034 dividend=5, divisor=4 -> valid after 2 cycles; quotient=0xFF, overflow=1; then dividend=0, divisor=9 -> quotient=0, overflow=0.
REQ-035 divisor=0, dividend=0x1234 -> valid after 2 cycles; quotient=0xFF, div_by_zero=1.
REQ-036 Start 1/4, re-pulse start with 3/7 mid-DIVIDE -> result 0x40 unaffected; start held on the valid cycle with 3/7 -> 109 after a further 10 cycles.
REQ-037 nRst pulsed during DIVIDE -> all outputs 0 immediately; no valid for 20 cycles without start.

Source files
------------

// File: rtl/param_seq_divider.sv
`default_nettype none
// ============================================================================
//  Module   : param_seq_divider
//  Purpose  : Sequential restoring divider, q = floor((dividend << FRAC) / divisor),
//             one quotient bit per cycle. Optional remainder port: DIVIDER_REMAINDER_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module param_seq_divider #(
   parameter int DW   = 16,
   parameter int QW   = 8,
   parameter int FRAC = 8
) (
   input  logic          clk,
   input  logic          nRst,
   input  logic          start,
   input  logic [DW-1:0] dividend,
   input  logic [DW-1:0] divisor,
   output logic [QW-1:0] quotient,
`ifdef DIVIDER_REMAINDER_EN
   output logic [DW-1:0] remainder,
`endif
   output logic          busy,
   output logic          valid,
   output logic          div_by_zero,
   output logic          overflow
);

   localparam int WW   = DW + FRAC + 1;
   // Compare width also covers the divisor shifted by up to QW bits.
   localparam int CW   = (WW > DW + QW) ? WW : DW + QW;
   localparam int CNTW = $clog2(QW + 1);

   localparam logic [1:0] C_IDLE   = 2'd0;
   localparam logic [1:0] C_LOAD   = 2'd1;
   localparam logic [1:0] C_DIVIDE = 2'd2;
   localparam logic [1:0] C_DONE   = 2'd3;

   logic [1:0]      state_q,    state_d;
   logic [CNTW-1:0] cnt_q,      cnt_d;
   logic [WW-1:0]   rem_q,      rem_d;
   logic [DW-1:0]   dvd_q,      dvd_d;
   logic [DW-1:0]   dvs_q,      dvs_d;
   logic [QW-1:0]   qacc_q,     qacc_d;
   logic [QW-1:0]   quotient_q, quotient_d;
   logic            valid_q,    valid_d;
   logic            dbz_q,      dbz_d;
   logic            ovf_q,      ovf_d;
`ifdef DIVIDER_REMAINDER_EN
   logic [DW-1:0]   remainder_q, remainder_d;
`endif

   logic [CW-1:0]   w_num;
   logic [CW-1:0]   w_lim;
   logic [CNTW-1:0] w_bit;
   logic [CW-1:0]   w_aligned;
   logic            w_ge;
   logic [WW-1:0]   w_sub;
   logic [WW-1:0]   w_rem_next;
   logic [QW-1:0]   w_qacc_next;
   logic            w_last;

   always_comb begin
      w_num       = CW'(dvd_q) << FRAC;
      w_lim       = CW'(dvs_q) << QW;
      w_bit       = CNTW'(QW - 1) - cnt_q;
      w_aligned   = CW'(dvs_q) << w_bit;
      w_ge        = (CW'(rem_q) >= w_aligned);
      w_sub       = rem_q - WW'(w_aligned);
      w_rem_next  = w_ge ? w_sub : rem_q;
      w_qacc_next = QW'({qacc_q, w_ge});
      w_last      = (cnt_q == CNTW'(QW - 1));
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rem_d      = rem_q;
      dvd_d      = dvd_q;
      dvs_d      = dvs_q;
      qacc_d     = qacc_q;
      quotient_d = quotient_q;
      valid_d    = 1'b0;
      dbz_d      = dbz_q;
      ovf_d      = ovf_q;
`ifdef DIVIDER_REMAINDER_EN
      remainder_d = remainder_q;
`endif
      case (state_q)
         C_IDLE, C_DONE: begin
            if (start) begin
               dvd_d   = dividend;
               dvs_d   = divisor;
               state_d = C_LOAD;
            end
         end
         C_LOAD: begin
            if (dvs_q == '0) begin
               state_d    = C_DONE;
               quotient_d = '1;
               dbz_d      = 1'b1;
               ovf_d      = 1'b0;
               valid_d    = 1'b1;
`ifdef DIVIDER_REMAINDER_EN
               remainder_d = '0;
`endif
            end else if (w_num >= w_lim) begin
               // Quotient would not fit in QW bits.
               state_d    = C_DONE;
               quotient_d = '1;
               dbz_d      = 1'b0;
               ovf_d      = 1'b1;
               valid_d    = 1'b1;
`ifdef DIVIDER_REMAINDER_EN
               remainder_d = '0;
`endif
            end else begin
               rem_d   = WW'(w_num);
               cnt_d   = '0;
               qacc_d  = '0;
               state_d = C_DIVIDE;
            end
         end
         C_DIVIDE: begin
            rem_d  = w_rem_next;
            qacc_d = w_qacc_next;
            cnt_d  = cnt_q + CNTW'(1);
            if (w_last) begin
               state_d    = C_DONE;
               quotient_d = w_qacc_next;
               dbz_d      = 1'b0;
               ovf_d      = 1'b0;
               valid_d    = 1'b1;
`ifdef DIVIDER_REMAINDER_EN
               remainder_d = DW'(w_rem_next);
`endif
            end
         end
         default: state_d = C_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_q    <= C_IDLE;
         cnt_q      <= '0;
         rem_q      <= '0;
         dvd_q      <= '0;
         dvs_q      <= '0;
         qacc_q     <= '0;
         quotient_q <= '0;
         valid_q    <= 1'b0;
         dbz_q      <= 1'b0;
         ovf_q      <= 1'b0;
`ifdef DIVIDER_REMAINDER_EN
         remainder_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rem_q      <= rem_d;
         dvd_q      <= dvd_d;
         dvs_q      <= dvs_d;
         qacc_q     <= qacc_d;
         quotient_q <= quotient_d;
         valid_q    <= valid_d;
         dbz_q      <= dbz_d;
         ovf_q      <= ovf_d;
`ifdef DIVIDER_REMAINDER_EN
         remainder_q <= remainder_d;
`endif
      end
   end

   assign quotient    = quotient_q;
   assign valid       = valid_q;
   assign div_by_zero = dbz_q;
   assign overflow    = ovf_q;
   assign busy        = (state_q == C_LOAD) || (state_q == C_DIVIDE);
`ifdef DIVIDER_REMAINDER_EN
   assign remainder   = remainder_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_param_seq_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_param_seq_divider
//  Purpose  : Directed self-checking bench for param_seq_divider (DW=16, QW=8, FRAC=8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_param_seq_divider;

   logic        clk;
   logic        nRst;
   logic        start;
   logic [15:0] dividend;
   logic [15:0] divisor;
   logic [7:0]  quotient;
`ifdef DIVIDER_REMAINDER_EN
   logic [15:0] remainder;
`endif
   logic        busy;
   logic        valid;
   logic        div_by_zero;
   logic        overflow;

   int total = 0;
   int bad   = 0;

   param_seq_divider #(.DW(16), .QW(8), .FRAC(8)) dut (
      .clk         (clk),
      .nRst        (nRst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .quotient    (quotient),
`ifdef DIVIDER_REMAINDER_EN
      .remainder   (remainder),
`endif
      .busy        (busy),
      .valid       (valid),
      .div_by_zero (div_by_zero),
      .overflow    (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Drive operands at a falling edge; the next rising edge accepts them.
   task automatic start_op(input logic [15:0] a, input logic [15:0] b);
      @(negedge clk);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // n = index of the rising edge (after acceptance) that first samples valid high.
   task automatic wait_valid(input int n0, output int n, output int nb);
      n  = n0;
      nb = 0;
      while (n < 40) begin
         @(negedge clk);
         n++;
         if (busy) nb++;
         if (valid) break;
      end
   endtask

   task automatic op(input string tag, input logic [15:0] a, input logic [15:0] b,
                     input int lat, input logic [7:0] q, input logic [15:0] r,
                     input logic dz, input logic ov);
      int n, nb;
      start_op(a, b);
      wait_valid(0, n, nb);
      chk({tag, ".latency"}, n, lat);
      chk({tag, ".busy_cycles"}, nb, lat - 1);
      chk({tag, ".quotient"}, {24'd0, quotient}, {24'd0, q});
      chk({tag, ".div_by_zero"}, {31'd0, div_by_zero}, {31'd0, dz});
      chk({tag, ".overflow"}, {31'd0, overflow}, {31'd0, ov});
`ifdef DIVIDER_REMAINDER_EN
      chk({tag, ".remainder"}, {16'd0, remainder}, {16'd0, r});
`endif
      @(negedge clk);
      chk({tag, ".valid_pulse"}, {31'd0, valid}, 32'd0);
   endtask

   initial begin
      int n, nb, cnt;
      nRst     = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;

      #12;
      chk("rst.quotient", {24'd0, quotient}, 32'd0);
      chk("rst.busy", {31'd0, busy}, 32'd0);
      chk("rst.valid", {31'd0, valid}, 32'd0);
      chk("rst.flags", {30'd0, div_by_zero, overflow}, 32'd0);
`ifdef DIVIDER_REMAINDER_EN
      chk("rst.remainder", {16'd0, remainder}, 32'd0);
`endif
      @(negedge clk);
      nRst = 1'b1;

      // Normal path: valid sampled 10 edges after acceptance, busy 9 cycles.
      op("d1_4",      16'd1,      16'd4,      10, 8'h40, 16'd0,      1'b0, 1'b0);
      op("d3_7",      16'd3,      16'd7,      10, 8'h6D, 16'd5,      1'b0, 1'b0);
      op("ovf5_4",    16'd5,      16'd4,      2,  8'hFF, 16'd0,      1'b0, 1'b1);
      op("d0_9",      16'd0,      16'd9,      10, 8'h00, 16'd0,      1'b0, 1'b0);
      // Largest quotient just below the overflow boundary, then exactly at it.
      op("edge_ff",   16'h00FF,   16'h0100,   10, 8'hFF, 16'd0,      1'b0, 1'b0);
      op("edge_ovf",  16'h0100,   16'h0100,   2,  8'hFF, 16'd0,      1'b0, 1'b1);
      op("wide",      16'hFFFE,   16'hFFFF,   10, 8'hFF, 16'hFEFF,   1'b0, 1'b0);
      op("dbz",       16'h1234,   16'h0000,   2,  8'hFF, 16'd0,      1'b1, 1'b0);

      // Start re-pulsed mid-DIVIDE must be ignored.
      start_op(16'd1, 16'd4);
      repeat (4) @(negedge clk);
      chk("hold.quotient", {24'd0, quotient}, 32'h0000_00FF);
      chk("hold.div_by_zero", {31'd0, div_by_zero}, 32'd1);
      dividend = 16'd3;
      divisor  = 16'd7;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      wait_valid(5, n, nb);
      chk("midstart.latency", n, 32'd10);
      chk("midstart.quotient", {24'd0, quotient}, 32'h0000_0040);

      // Start held on the valid cycle launches the next operation.
      dividend = 16'd3;
      divisor  = 16'd7;
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_valid(0, n, nb);
      chk("backtoback.latency", n, 32'd10);
      chk("backtoback.quotient", {24'd0, quotient}, 32'h0000_006D);
`ifdef DIVIDER_REMAINDER_EN
      chk("backtoback.remainder", {16'd0, remainder}, 32'd5);
`endif

      // Asynchronous reset in the middle of DIVIDE.
      start_op(16'd1, 16'd4);
      repeat (4) @(negedge clk);
      #2 nRst = 1'b0;
      #1;
      chk("midrst.quotient", {24'd0, quotient}, 32'd0);
      chk("midrst.busy", {31'd0, busy}, 32'd0);
      chk("midrst.valid", {31'd0, valid}, 32'd0);
      chk("midrst.flags", {30'd0, div_by_zero, overflow}, 32'd0);
`ifdef DIVIDER_REMAINDER_EN
      chk("midrst.remainder", {16'd0, remainder}, 32'd0);
`endif
      @(negedge clk);
      nRst = 1'b1;
      cnt  = 0;
      repeat (20) begin
         @(negedge clk);
         if (valid || busy) cnt++;
      end
      chk("midrst.no_valid", cnt, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
